// File: rtl/eth_pkg.sv
// Shared RMII receive definitions: FSM states, preamble/SFD dibits, frame limits.
// Optional per-frame statistics are enabled with RMII_RX_STATS_EN.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_CHECK,
    ST_DROP
  } rx_state_t;

  localparam logic [1:0]  PRE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT = 2'b11;
  localparam int unsigned MIN_FRAME = 64;
  localparam int unsigned MAX_FRAME = 1518;
  localparam int unsigned STAT_W    = 16;

endpackage

// File: rtl/rmii_rx_mac_crc32.sv
// Byte-wide Ethernet CRC-32 (reflected 0xEDB88320, preset all-ones).
// crc[31:24] is the first FCS byte on the wire, crc[7:0] the last.
module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] state;

  function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '1;
    end else if (vld) begin
      state <= next_crc(state, data);
    end
  end

  assign crc = ~{state[7:0], state[15:8], state[23:16], state[31:24]};

endmodule

// File: rtl/rmii_rx_mac.sv
// RMII receive front end: preamble/SFD strip, dibit-to-byte assembly, FCS/length check.
// Define RMII_RX_STATS_EN to add saturating stat_ok/stat_bad frame counters.
module rmii_rx_mac
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = MIN_FRAME,
  parameter int unsigned MAX_LEN = MAX_FRAME,
  parameter int unsigned LEN_W   = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eth_crsdv,
  input  logic       eth_rxerr,
  input  logic [1:0] eth_rxd,
  output logic       out_vld,
  output logic [7:0] out_dat,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err
`ifdef RMII_RX_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_bad
`endif
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic             crsdv_q, rxerr_q;
  logic [1:0]       rxd_q;
  rx_state_t        state;
  logic [1:0]       dibit_cnt;
  logic [7:0]       shreg;
  logic [LEN_W-1:0] byte_cnt;
  logic [7:0]       hold [5];
  logic [2:0]       hold_cnt;
  logic             err_flag, sof_pend, crc_clr;
  logic [7:0]       byte_new;
  logic             push, crc_vld, crc_rst, frame_bad;
  logic [31:0]      crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crsdv_q <= 1'b0;
      rxerr_q <= 1'b0;
      rxd_q   <= '0;
    end else begin
      crsdv_q <= eth_crsdv;
      rxerr_q <= eth_rxerr;
      rxd_q   <= eth_rxd;
    end
  end

  // hold[4] is the oldest byte; CRC consumes a byte as it shifts into hold[4].
  always_comb begin
    byte_new  = {rxd_q, shreg[7:2]};
    push      = (state == ST_DATA) && crsdv_q && (dibit_cnt == 2'd3) && (byte_cnt < MAX_L);
    crc_vld   = push && (hold_cnt >= 3'd4);
    frame_bad = err_flag || (dibit_cnt != 2'd0) || (byte_cnt < MIN_L) ||
                ({hold[3], hold[2], hold[1], hold[0]} != crc);
  end

  assign crc_rst = rst | crc_clr;

  crc32 u_crc32 (
    .clk  (clk),
    .rst  (crc_rst),
    .vld  (crc_vld),
    .data (hold[3]),
    .crc  (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dibit_cnt <= '0;
      shreg     <= '0;
      byte_cnt  <= '0;
      hold      <= '{default: '0};
      hold_cnt  <= '0;
      err_flag  <= 1'b0;
      sof_pend  <= 1'b0;
      crc_clr   <= 1'b0;
      out_vld   <= 1'b0;
      out_dat   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      out_err <= 1'b0;
      crc_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (crsdv_q) begin
            if (rxd_q == PRE_DIBIT)  state <= ST_PRE;
            else if (rxd_q != 2'b00) state <= ST_DROP;
          end
        end
        ST_PRE: begin
          if (!crsdv_q) begin
            state <= ST_IDLE;
          end else if (rxd_q == SFD_DIBIT) begin
            state     <= ST_DATA;
            dibit_cnt <= '0;
            byte_cnt  <= '0;
            hold_cnt  <= '0;
            err_flag  <= 1'b0;
            sof_pend  <= 1'b1;
            crc_clr   <= 1'b1;
          end else if (rxd_q != PRE_DIBIT) begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (!crsdv_q) begin
            state <= ST_CHECK;
          end else begin
            if (rxerr_q) err_flag <= 1'b1;
            dibit_cnt <= dibit_cnt + 2'd1;
            shreg     <= byte_new;
            if (push) begin
              byte_cnt <= byte_cnt + LEN_W'(1);
              hold[0]  <= byte_new;
              for (int unsigned i = 1; i < 5; i++) hold[i] <= hold[i-1];
              if (hold_cnt == 3'd5) begin
                out_vld  <= 1'b1;
                out_dat  <= hold[4];
                out_sof  <= sof_pend;
                sof_pend <= 1'b0;
              end else begin
                hold_cnt <= hold_cnt + 3'd1;
              end
            end else if (dibit_cnt == 2'd3) begin
              err_flag <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (hold_cnt == 3'd5) begin
            out_vld  <= 1'b1;
            out_dat  <= hold[4];
            out_sof  <= sof_pend;
            out_eof  <= 1'b1;
            out_err  <= frame_bad;
            sof_pend <= 1'b0;
          end
        end
        ST_DROP: begin
          if (!crsdv_q) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RMII_RX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ok  <= '0;
      stat_bad <= '0;
    end else if (state == ST_CHECK) begin
      if ((hold_cnt == 3'd5) && !frame_bad) begin
        if (stat_ok != '1) stat_ok <= stat_ok + STAT_W'(1);
      end else if (stat_bad != '1) begin
        stat_bad <= stat_bad + STAT_W'(1);
      end
    end
  end
`endif

endmodule
